// File: rtl/yx_event_log.sv
// Timestamped change log for the debounced YX status vector; YX_EVT_COALESCE_EN merges same-tick changes into the tail entry.
// Latency: a yx_in change is queued 3 fpga_clk edges after it settles; head entry is show-ahead.
// Backpressure: none upstream; a full FIFO drops new events and sets sticky overflow until clr.
module yx_event_log #(
  parameter int YX_WIDTH   = 4,
  parameter int TS_WIDTH   = 16,
  parameter int TICK_DIV   = 24000,
  parameter int FIFO_DEPTH = 8,
  parameter int PTR_W      = 3
) (
  input  logic                fpga_clk,
  input  logic                sys_reset,
  input  logic [YX_WIDTH-1:0] yx_in,
  input  logic                pop,
  input  logic                clr,
  output logic                evt_valid,
  output logic [YX_WIDTH-1:0] evt_state,
  output logic [YX_WIDTH-1:0] evt_mask,
  output logic [TS_WIDTH-1:0] evt_ts,
  output logic [PTR_W:0]      evt_count,
  output logic                overflow,
  output logic                irq_out
);

  localparam int PS_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

  logic [YX_WIDTH-1:0] s1, s2, prev;
  logic                primed;
  logic [1:0]          prime_cnt;
  logic [PS_W-1:0]     ps;
  logic [TS_WIDTH-1:0] ts;

  logic [PTR_W-1:0]    wp, rp;
  logic [PTR_W:0]      count;

  logic [YX_WIDTH-1:0] mem_state [FIFO_DEPTH];
  logic [YX_WIDTH-1:0] mem_mask  [FIFO_DEPTH];
  logic [TS_WIDTH-1:0] mem_ts    [FIFO_DEPTH];

  logic [YX_WIDTH-1:0] chg;
  logic                push, empty, full, do_pop, do_wr, drop, merge;

  // Priming waits until the synchroniser has flushed its reset zeros, so
  // a nonzero level held across reset never shows up as a change.
  always_ff @(posedge fpga_clk or posedge sys_reset) begin
    if (sys_reset) begin
      s1        <= '0;
      s2        <= '0;
      prev      <= '0;
      primed    <= 1'b0;
      prime_cnt <= '0;
      ps        <= '0;
      ts        <= '0;
    end else begin
      s1   <= yx_in;
      s2   <= s1;
      prev <= s2;
      if (!primed) begin
        prime_cnt <= prime_cnt + 2'd1;
        if (prime_cnt == 2'd2)
          primed <= 1'b1;
      end
      if (ps == PS_LAST) begin
        ps <= '0;
        ts <= ts + TS_WIDTH'(1);
      end else begin
        ps <= ps + PS_W'(1);
      end
    end
  end

  assign chg    = s2 ^ prev;
  assign push   = primed && (chg != '0);
  assign empty  = (count == '0);
  assign full   = (count == DEPTH_C);
  assign do_pop = pop && !empty;

`ifdef YX_EVT_COALESCE_EN
  logic [PTR_W-1:0] tail;
  assign tail  = wp - PTR_W'(1);
  // Never merge into the head while it is being popped away.
  assign merge = push && !empty && (mem_ts[tail] == ts) &&
                 !(do_pop && (count == (PTR_W + 1)'(1)));
`else
  assign merge = 1'b0;
`endif

  assign do_wr = push && !merge && (!full || do_pop);
  assign drop  = push && !merge && full && !do_pop;

  always_ff @(posedge fpga_clk or posedge sys_reset) begin
    if (sys_reset) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_wr)
        wp <= wp + PTR_W'(1);
      if (do_pop)
        rp <= rp + PTR_W'(1);
      count <= count + (PTR_W + 1)'(do_wr) - (PTR_W + 1)'(do_pop);
      if (drop)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge fpga_clk) begin
    if (!clr) begin
      if (do_wr) begin
        mem_state[wp] <= s2;
        mem_mask[wp]  <= chg;
        mem_ts[wp]    <= ts;
      end
`ifdef YX_EVT_COALESCE_EN
      else if (merge) begin
        mem_state[tail] <= s2;
        mem_mask[tail]  <= mem_mask[tail] | chg;
      end
`endif
    end
  end

  assign evt_valid = !empty;
  assign evt_state = empty ? '0 : mem_state[rp];
  assign evt_mask  = empty ? '0 : mem_mask[rp];
  assign evt_ts    = empty ? '0 : mem_ts[rp];
  assign evt_count = count;
  assign irq_out   = evt_valid | overflow;

endmodule

// File: tb/tb_yx_event_log.sv
// Directed bench for yx_event_log (TICK_DIV=4, TS_WIDTH=4); coalesce expectations follow YX_EVT_COALESCE_EN.
module tb_yx_event_log;

  logic       fpga_clk = 1'b0;
  logic       sys_reset;
  logic [3:0] yx_in;
  logic       pop, clr;
  logic       evt_valid;
  logic [3:0] evt_state, evt_mask, evt_ts;
  logic [3:0] evt_count;
  logic       overflow, irq_out;

  int checks = 0;
  int errors = 0;
  int ecnt;

  yx_event_log #(
    .YX_WIDTH(4), .TS_WIDTH(4), .TICK_DIV(4), .FIFO_DEPTH(8), .PTR_W(3)
  ) dut (
    .fpga_clk(fpga_clk), .sys_reset(sys_reset), .yx_in(yx_in), .pop(pop), .clr(clr),
    .evt_valid(evt_valid), .evt_state(evt_state), .evt_mask(evt_mask), .evt_ts(evt_ts),
    .evt_count(evt_count), .overflow(overflow), .irq_out(irq_out)
  );

  always #5 fpga_clk = ~fpga_clk;

  // Edges since reset release: after edge e, ecnt == e.
  always @(posedge fpga_clk or posedge sys_reset)
    if (sys_reset) ecnt <= 0;
    else           ecnt <= ecnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic goto_edge(input int e);
    int guard = 0;
    while (ecnt < e && guard < 2000) begin
      @(negedge fpga_clk);
      guard++;
    end
    if (ecnt < e) begin
      errors++;
      $display("FAIL timeout: edge %0d required %0d", ecnt, e);
    end
  endtask

  initial begin
    sys_reset = 1'b1;
    yx_in = 4'b1010;
    pop = 1'b0;
    clr = 1'b0;
    repeat (3) @(negedge fpga_clk);
    check("rst_valid", evt_valid, 0);
    check("rst_count", evt_count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_irq", irq_out, 0);
    sys_reset = 1'b0;

    // Level held across reset must not produce an event.
    goto_edge(6);
    check("prime_valid", evt_valid, 0);
    check("prime_count", evt_count, 0);
    check("prime_irq", irq_out, 0);

    yx_in = 4'b0000;
    goto_edge(9);
    check("e1_count", evt_count, 1);
    check("e1_state", evt_state, 4'b0000);
    check("e1_mask", evt_mask, 4'b1010);
    check("e1_ts", evt_ts, 2);
    pop = 1'b1;
    goto_edge(10);
    pop = 1'b0;
    check("e1_popped", evt_valid, 0);

    // Single change after 10 ticks.
    goto_edge(40);
    yx_in = 4'b0001;
    goto_edge(42);
    check("lat_not_yet", evt_valid, 0);
    goto_edge(43);
    check("one_valid", evt_valid, 1);
    check("one_state", evt_state, 1);
    check("one_mask", evt_mask, 1);
    check("one_ts", evt_ts, 10);
    check("one_irq", irq_out, 1);
    pop = 1'b1;
    goto_edge(44);
    pop = 1'b0;
    check("one_pop_valid", evt_valid, 0);
    check("one_pop_state", evt_state, 0);
    check("one_pop_mask", evt_mask, 0);
    check("one_pop_ts", evt_ts, 0);

    // Nine changes, one per tick, no pop.
    for (int k = 0; k < 9; k++) begin
      goto_edge(44 + 4 * k);
      yx_in = 4'(k + 2);
    end
    goto_edge(80);
    check("fill_count", evt_count, 8);
    check("fill_ovf", overflow, 1);
    check("fill_irq", irq_out, 1);
    check("fill_head_state", evt_state, 2);
    check("fill_head_mask", evt_mask, 4'b0011);
    check("fill_head_ts", evt_ts, 11);
    pop = 1'b1;
    goto_edge(87);
    pop = 1'b0;
    check("fill_last_count", evt_count, 1);
    check("fill_last_state", evt_state, 9);
    check("fill_last_mask", evt_mask, 4'b0001);
    check("fill_last_ts", evt_ts, 2);
    pop = 1'b1;
    goto_edge(88);
    pop = 1'b0;
    check("drain_valid", evt_valid, 0);
    check("drain_ovf", overflow, 1);
    check("drain_irq", irq_out, 1);
    clr = 1'b1;
    goto_edge(89);
    clr = 1'b0;
    check("clr_ovf", overflow, 0);
    check("clr_irq", irq_out, 0);

    // Fill to eight, then a change that lands together with a pop.
    for (int k = 0; k < 8; k++) begin
      goto_edge(92 + 4 * k);
      yx_in = 4'(k + 11);
    end
    goto_edge(124);
    check("full2_count", evt_count, 8);
    yx_in = 4'd3;
    goto_edge(126);
    pop = 1'b1;
    goto_edge(127);
    check("pp_count", evt_count, 8);
    check("pp_ovf", overflow, 0);
    goto_edge(134);
    pop = 1'b0;
    check("pp_tail_count", evt_count, 1);
    check("pp_tail_state", evt_state, 3);
    check("pp_tail_mask", evt_mask, 4'b0001);
    check("pp_tail_ts", evt_ts, 15);
    check("pp_tail_ovf", overflow, 0);
    pop = 1'b1;
    goto_edge(135);
    pop = 1'b0;
    check("pp_empty", evt_valid, 0);

    // Tick 65 wraps to 1 in a 4-bit timestamp.
    goto_edge(258);
    yx_in = 4'd4;
    goto_edge(261);
    check("wrap_valid", evt_valid, 1);
    check("wrap_ts", evt_ts, 1);
    check("wrap_mask", evt_mask, 4'b0111);
    pop = 1'b1;
    goto_edge(262);
    pop = 1'b0;

    // clr on the same edge as a push: push is lost, no overflow.
    goto_edge(264);
    yx_in = 4'd7;
    goto_edge(266);
    clr = 1'b1;
    goto_edge(267);
    clr = 1'b0;
    check("clrpush_count", evt_count, 0);
    check("clrpush_ovf", overflow, 0);
    goto_edge(270);
    check("clrpush_later", evt_count, 0);

    // Bits 0 and 2 change one clock apart inside one tick.
    goto_edge(272);
    yx_in = 4'b0110;
    goto_edge(273);
    yx_in = 4'b0010;
    goto_edge(276);
    check("co_ts", evt_ts, 4);
`ifdef YX_EVT_COALESCE_EN
    check("co_count", evt_count, 1);
    check("co_mask", evt_mask, 4'b0101);
    check("co_state", evt_state, 4'b0010);
    check("co_ovf", overflow, 0);
`else
    check("co_count", evt_count, 2);
    check("co_mask0", evt_mask, 4'b0001);
    check("co_state0", evt_state, 4'b0110);
    pop = 1'b1;
    goto_edge(277);
    pop = 1'b0;
    check("co_count1", evt_count, 1);
    check("co_mask1", evt_mask, 4'b0100);
    check("co_state1", evt_state, 4'b0010);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
